// File: rtl/demux_stream_1n.sv
// Registered 1:N stream demux: each accepted beat lands in a one-entry holding register per channel,
// one cycle after acceptance; in_ready drops only while the target channel is full and not draining.
module demux_stream_1n #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int CNTW  = 8,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  output logic [N*WIDTH-1:0]   out_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [SELW-1:0]      rr_ptr,
  output logic [CNTW-1:0]      drop_cnt,
  output logic                 drop_err
);

  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [SELW-1:0] tgt;
  logic            tgt_busy;
  logic            in_range;
  logic            accept;
  logic            drop;

  assign tgt      = mode ? rr_ptr : in_sel;
  assign in_range = (32'(tgt) < N);

  // Out-of-range targets are never busy, so they are always accepted and then dropped.
  always_comb begin
    tgt_busy = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (tgt == SELW'(k)) tgt_busy = out_valid[k] & ~out_ready[k];
    end
  end

  assign in_ready = ~tgt_busy;
  assign accept   = in_valid & in_ready;
  assign drop     = accept & ~in_range;

  // A load wins over a drain, so a channel drained and reloaded in one cycle stays valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && in_range && (tgt == SELW'(k))) begin
          out_valid[k]                <= 1'b1;
          out_data[k*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (mode && accept) begin
      rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= drop;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_stream_1n.sv
// Bench for demux_stream_1n: directed scenarios on N=4 and N=3 instances plus a randomized run against a channel-array model.
module tb_demux_stream_1n;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [7:0]  drop_cnt;
  logic        drop_err;

  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic        b_mode;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic [1:0]  b_rr_ptr;
  logic [7:0]  b_drop_cnt;
  logic        b_drop_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_stream_1n #(.WIDTH(8), .N(4), .CNTW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rr_ptr(rr_ptr), .drop_cnt(drop_cnt), .drop_err(drop_err)
  );

  demux_stream_1n #(.WIDTH(8), .N(3), .CNTW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .rr_ptr(b_rr_ptr), .drop_cnt(b_drop_cnt), .drop_err(b_drop_err)
  );

  // Reference model: per-channel occupancy and last data, round-robin index, drop statistics.
  bit         mv[4];
  logic [7:0] md[4];
  int         mrr;
  int         mcnt;
  bit         merr;

  function automatic void m_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = 0;
      md[k] = 8'h00;
    end
    mrr  = 0;
    mcnt = 0;
    merr = 0;
  endfunction

  function automatic bit m_ready(int t, logic [3:0] rdy);
    if (t >= 4) return 1'b1;
    return !mv[t] || rdy[t];
  endfunction

  function automatic void m_step(bit v, int sel, bit md_rr, logic [3:0] rdy, logic [7:0] d);
    int t;
    bit acc;
    t   = md_rr ? mrr : sel;
    acc = v && m_ready(t, rdy);
    for (int k = 0; k < 4; k++) if (mv[k] && rdy[k]) mv[k] = 0;
    merr = 0;
    if (acc) begin
      if (t < 4) begin
        mv[t] = 1;
        md[t] = d;
      end else begin
        merr = 1;
        if (mcnt < 255) mcnt++;
      end
      if (md_rr) mrr = (mrr + 1) % 4;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; mode = 1'b0; out_ready = '0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_mode = 1'b0; b_out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0000", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    total++; if (rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_rr_ptr got=%0d want=0", rr_ptr); end
    total++; if (drop_cnt !== 8'd0 || drop_err !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0d/%b want=0/0", drop_cnt, drop_err); end
    @(negedge clk) rst_n = 1'b1;
    tick();
    // Park beats on ch0 and ch2 with no consumer, then reset mid-stream.
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h5A;
    tick();
    in_sel = 2'd2; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0101) begin bad++; $display("FAIL pre_reset_valid got=%b want=0101", out_valid); end
    total++; if (out_data[23:16] !== 8'hC3) begin bad++; $display("FAIL pre_reset_data got=%h want=c3", out_data[23:16]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 4'b0 || out_data !== 32'h0) begin bad++; $display("FAIL async_reset got=%b/%h want=0/0", out_valid, out_data); end
    total++; if (rr_ptr !== 2'd0 || drop_cnt !== 8'd0) begin bad++; $display("FAIL async_reset_ctr got=%0d/%0d want=0/0", rr_ptr, drop_cnt); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    out_ready = 4'hF; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = 2'(i); in_data = 8'hA1 + 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir_ready beat=%0d got=%b want=1", i, in_ready); end
      tick();
      total++; if (out_valid !== (4'b0001 << i)) begin bad++; $display("FAIL dir_valid beat=%0d got=%b want=%b", i, out_valid, 4'b0001 << i); end
      total++; if (out_data[i*8 +: 8] !== 8'hA1 + 8'(i)) begin bad++; $display("FAIL dir_data beat=%0d got=%h want=%h", i, out_data[i*8 +: 8], 8'hA1 + 8'(i)); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL dir_drained got=%b want=0000", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 4'b1011; mode = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h11;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_first_ready got=%b want=1", in_ready); end
    tick();
    in_data = 8'h22;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_blocked_ready got=%b want=0", in_ready); end
    tick();
    total++; if (out_valid[2] !== 1'b1 || out_data[23:16] !== 8'h11) begin bad++; $display("FAIL stall_hold got=%b/%h want=1/11", out_valid[2], out_data[23:16]); end
    in_sel = 2'd1; in_data = 8'h33;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_other_ready got=%b want=1", in_ready); end
    tick();
    total++; if (out_valid !== 4'b0110 || out_data[15:8] !== 8'h33) begin bad++; $display("FAIL stall_other got=%b/%h want=0110/33", out_valid, out_data[15:8]); end
    in_sel = 2'd2; in_data = 8'h22; out_ready = 4'hF;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h22) begin bad++; $display("FAIL stall_release got=%b/%h want=0100/22", out_valid, out_data[23:16]); end
    tick();
  endtask

  task automatic test_round_robin();
    out_ready = 4'hF; mode = 1'b1; in_sel = 2'd3; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_ready beat=%0d got=%b want=1", i, in_ready); end
      tick();
      total++; if (out_valid !== (4'b0001 << (i % 4)) || out_data[(i%4)*8 +: 8] !== 8'(i)) begin
        bad++; $display("FAIL rr_route beat=%0d got=%b/%h want=%b/%h", i, out_valid, out_data[(i%4)*8 +: 8], 4'b0001 << (i % 4), 8'(i));
      end
    end
    total++; if (rr_ptr !== 2'd2) begin bad++; $display("FAIL rr_ptr_end got=%0d want=2", rr_ptr); end
    // Stall ch2 and go round once: the pointer must then wait on ch2 even though the others are empty.
    out_ready = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h80 + 8'(i);
      tick();
    end
    in_data = 8'h84;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rr_no_skip got=%b want=0", in_ready); end
    tick();
    total++; if (rr_ptr !== 2'd2 || out_data[23:16] !== 8'h80) begin bad++; $display("FAIL rr_wait got=%0d/%h want=2/80", rr_ptr, out_data[23:16]); end
    mode = 1'b0; in_sel = 2'd0; in_data = 8'h85;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_to_directed_ready got=%b want=1", in_ready); end
    tick();
    total++; if (rr_ptr !== 2'd2 || out_data[7:0] !== 8'h85) begin bad++; $display("FAIL directed_holds_rr got=%0d/%h want=2/85", rr_ptr, out_data[7:0]); end
    in_valid = 1'b0; out_ready = 4'hF;
    tick();
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL rr_drained got=%b want=0000", out_valid); end
  endtask

  task automatic test_drop();
    b_out_ready = 3'b111; b_mode = 1'b0; b_in_sel = 2'd3; b_in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b_in_data = 8'($urandom);
      #1;
      total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL drop_ready beat=%0d got=%b want=1", i, b_in_ready); end
      tick();
      total++; if (b_out_valid !== 3'b0 || b_drop_err !== 1'b1) begin bad++; $display("FAIL drop_pulse beat=%0d got=%b/%b want=000/1", i, b_out_valid, b_drop_err); end
      total++; if (b_drop_cnt !== 8'((i + 1 > 255) ? 255 : i + 1)) begin bad++; $display("FAIL drop_cnt beat=%0d got=%0d want=%0d", i, b_drop_cnt, (i + 1 > 255) ? 255 : i + 1); end
    end
    b_in_valid = 1'b0;
    tick();
    total++; if (b_drop_err !== 1'b0 || b_drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_idle got=%b/%0d want=0/255", b_drop_err, b_drop_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 4'b0001; mode = 1'b0; in_sel = 2'd0; in_valid = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'h40 + 8'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready beat=%0d got=%b want=1", i, in_ready); end
      tick();
      total++; if (out_valid[0] !== 1'b1 || out_data[7:0] !== 8'h40 + 8'(i)) begin
        bad++; $display("FAIL b2b_beat beat=%0d got=%b/%h want=1/%h", i, out_valid[0], out_data[7:0], 8'h40 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 4'b0) begin bad++; $display("FAIL b2b_drained got=%b want=0000", out_valid); end
  endtask

  task automatic test_random();
    logic [3:0]  ev;
    logic [31:0] ed;
    bit          er;
    rst_n = 1'b0;
    in_valid = 1'b0; mode = 1'b0; out_ready = '0;
    #2;
    m_reset();
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      #1;
      er = m_ready(mode ? mrr : int'(in_sel), out_ready);
      total++; if (in_ready !== er) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready, er); end
      m_step(in_valid, int'(in_sel), mode, out_ready, in_data);
      tick();
      for (int k = 0; k < 4; k++) begin
        ev[k] = mv[k];
        ed[k*8 +: 8] = md[k];
      end
      total++; if (out_valid !== ev || out_data !== ed) begin bad++; $display("FAIL rand_out cyc=%0d got=%b/%h want=%b/%h", c, out_valid, out_data, ev, ed); end
      total++; if (rr_ptr !== 2'(mrr) || drop_cnt !== 8'(mcnt) || drop_err !== merr) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", c, rr_ptr, drop_cnt, drop_err, mrr, mcnt, merr);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_round_robin();
    test_drop();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
